// File: rtl/tm_rs_pkg.sv
// Shared constants and GF(2^8) helpers for the CCSDS TM Reed-Solomon encoder.
// Field x^8+x^7+x^2+x+1; generator roots alpha^(11*(128-TT+j)), j=0..2TT-1.
package tm_rs_pkg;

  localparam logic [8:0] FIELD_POLY = 9'h187;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} rs_state_e;

  // Multiply by a constant; with c constant this reduces to an XOR network.
  function automatic logic [7:0] gf_cmul(logic [7:0] a, logic [7:0] c);
    logic [7:0] p, s;
    p = '0;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p ^= s;
      s = {s[6:0], 1'b0} ^ (s[7] ? FIELD_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e % 255; i++) r = gf_cmul(r, 8'h02);
    return r;
  endfunction

  // Monic generator, returned without its leading x^2TT term.
  function automatic logic [31:0][7:0] gen_poly(int tt);
    logic [32:0][7:0] g;
    logic [7:0] r, step;
    g = '0;
    g[0] = 8'h01;
    r = gf_pow(11 * (128 - tt));
    step = gf_pow(11);
    for (int j = 0; j < 2 * tt; j++) begin
      for (int d = 2 * tt; d > 0; d--) g[d] = g[d-1] ^ gf_cmul(g[d], r);
      g[0] = gf_cmul(g[0], r);
      r = gf_cmul(r, step);
    end
    return g[31:0];
  endfunction

  localparam logic [15:0][7:0] G8  = 128'(gen_poly(8));
  localparam logic [31:0][7:0] G16 = gen_poly(16);

  function automatic logic gf_trace(logic [7:0] a);
    logic [7:0] t, acc;
    t = a;
    acc = a;
    for (int i = 1; i < 8; i++) begin
      t = gf_cmul(t, t);
      acc ^= t;
    end
    return acc[0];
  endfunction

  // Row r of a matrix is the mask of input bits XORed into output bit r.
  function automatic logic [7:0] mat_apply(logic [7:0][7:0] m, logic [7:0] x);
    logic [7:0] y;
    for (int r = 0; r < 8; r++) y[r] = ^(m[r] & x);
    return y;
  endfunction

  // Berlekamp coordinate k = Tr(x * alpha^(117k)).
  function automatic logic [7:0][7:0] mk_to_dual();
    logic [7:0][7:0] m;
    logic [7:0] b, beta;
    m = '0;
    b = 8'h01;
    beta = gf_pow(117);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) m[r][c] = gf_trace(gf_cmul(8'(1 << c), b));
      b = gf_cmul(b, beta);
    end
    return m;
  endfunction

  function automatic logic [7:0][7:0] mk_from_dual(logic [7:0][7:0] td);
    logic [7:0][7:0] m;
    logic [7:0] xv;
    m = '0;
    for (int x = 0; x < 256; x++) begin
      xv = 8'(x);
      for (int b = 0; b < 8; b++)
        if (mat_apply(td, xv) == 8'(1 << b))
          for (int r = 0; r < 8; r++) m[r][b] = xv[r];
    end
    return m;
  endfunction

  localparam logic [7:0][7:0] TO_DUAL   = mk_to_dual();
  localparam logic [7:0][7:0] FROM_DUAL = mk_from_dual(TO_DUAL);

endpackage

// File: rtl/tm_rs_parity_ring.sv
// Ring of IDEPTH parity banks sharing one set of 2TT constant multipliers.
// Bank 0 is always the active lane; every step rotates the ring by one bank.
module tm_rs_parity_ring
  import tm_rs_pkg::*;
#(
  parameter int TT     = 16,
  parameter int IDEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       data_step,
  input  logic       par_step,
  input  logic [7:0] din,
  output logic [7:0] par_sym
);
  localparam int NP = 2 * TT;
  localparam logic [31:0][7:0] GEN = (TT == 8) ? {128'h0, G8} : G16;

  logic [IDEPTH-1:0][NP-1:0][7:0] bank, base, bank_nxt;
  logic [NP-1:0][7:0] b0_nxt;
  logic [7:0] fb;

  // clr arrives together with the first data step, so that step sees empty banks.
  assign base    = clr ? '0 : bank;
  assign fb      = din ^ base[0][NP-1];
  assign par_sym = bank[0][NP-1];

  always_comb begin
    b0_nxt = '0;
    if (data_step) begin
      b0_nxt[0] = gf_cmul(fb, GEN[0]);
      for (int k = 1; k < NP; k++) b0_nxt[k] = base[0][k-1] ^ gf_cmul(fb, GEN[k]);
    end else begin
      for (int k = 1; k < NP; k++) b0_nxt[k] = base[0][k-1];
    end
  end

  always_comb begin
    bank_nxt = base;
    for (int i = 0; i < IDEPTH - 1; i++) bank_nxt[i] = base[i+1];
    bank_nxt[IDEPTH-1] = b0_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                        bank <= '0;
    else if (data_step || par_step) bank <= bank_nxt;
  end

endmodule

// File: rtl/tm_rs_interleave_enc.sv
// CCSDS TM RS encoder top: FSM, counters, registered outputs, optional basis conversion.
// Define TM_RSENC_DUALBASIS_EN for dual-basis (Berlekamp) DATAINP/CODEOUTP.
module tm_rs_interleave_enc
  import tm_rs_pkg::*;
#(
  parameter int TT     = 16,
  parameter int IDEPTH = 1,
  parameter int NN     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       start,
  input  logic [7:0] vfill,
  input  logic [7:0] datainp,
  output logic [7:0] codeoutp,
  output logic       rdy,
  output logic       rfs,
  output logic       rfd
);
  localparam int NP   = 2 * TT;
  localparam int KMAX = NN - NP;
  localparam int CW   = 11;
  localparam logic [CW-1:0] P_LAST = CW'(IDEPTH * NP - 1);

  rs_state_e     state;
  logic [CW-1:0] sym_cnt, d_last, par_cnt, k_calc, d_calc;
  logic [7:0]    vf_clamp, din_conv, par_sym, par_out;
  logic          take, data_step, par_step;

  assign vf_clamp  = (vfill > 8'(KMAX - 1)) ? 8'(KMAX - 1) : vfill;
  assign k_calc    = CW'(KMAX) - CW'(vf_clamp);
  assign d_calc    = CW'(IDEPTH) * k_calc - CW'(1);
  assign take      = clken && start && (state == IDLE);
  assign data_step = take || (clken && (state == DATA));
  assign par_step  = clken && (state == PARITY);

`ifdef TM_RSENC_DUALBASIS_EN
  assign din_conv = mat_apply(FROM_DUAL, datainp);
  assign par_out  = mat_apply(TO_DUAL, par_sym);
`else
  assign din_conv = datainp;
  assign par_out  = par_sym;
`endif

  tm_rs_parity_ring #(.TT(TT), .IDEPTH(IDEPTH)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .clr       (take),
    .data_step (data_step),
    .par_step  (par_step),
    .din       (din_conv),
    .par_sym   (par_sym)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      codeoutp <= '0;
      rdy      <= 1'b0;
      rfs      <= 1'b1;
      rfd      <= 1'b0;
      sym_cnt  <= '0;
      d_last   <= '0;
      par_cnt  <= '0;
    end else if (clken) begin
      rdy <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          codeoutp <= datainp;
          rdy      <= 1'b1;
          rfs      <= 1'b0;
          d_last   <= d_calc;
          sym_cnt  <= CW'(1);
          par_cnt  <= '0;
          if (d_calc == '0) state <= PARITY;
          else begin
            state <= DATA;
            rfd   <= 1'b1;
          end
        end
        DATA: begin
          codeoutp <= datainp;
          rdy      <= 1'b1;
          sym_cnt  <= sym_cnt + CW'(1);
          if (sym_cnt == d_last) begin
            state <= PARITY;
            rfd   <= 1'b0;
          end
        end
        PARITY: begin
          codeoutp <= par_out;
          rdy      <= 1'b1;
          par_cnt  <= par_cnt + CW'(1);
          if (par_cnt == P_LAST) begin
            state <= IDLE;
            rfs   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_rs_interleave_enc.sv
// Scoreboard bench: three encoder configurations (16/1, 16/5, 8/2), expected
// codewords built by polynomial long division against a locally derived generator.
module tb_tm_rs_interleave_enc;
  logic       clk = 1'b0, rst = 1'b1, clken = 1'b0;
  logic [2:0] start_a = '0;
  logic [7:0] vfill_a [3];
  logic [7:0] din_a   [3];
  logic [7:0] cout_a  [3];
  logic       rdy_a [3], rfs_a [3], rfd_a [3];
  int         n_chk = 0, n_fail = 0;

  typedef struct { int unit; int val; } exp_t;
  exp_t sbq [$];
  logic [7:0] gtab [2][0:32];
  localparam int TT_OF [3] = '{16, 16, 8};
  localparam int ID_OF [3] = '{1, 5, 2};
  localparam int LIM = 20000;

  always #5 clk = ~clk;

  tm_rs_interleave_enc #(.TT(16), .IDEPTH(1)) u0 (.clk(clk), .rst(rst), .clken(clken),
    .start(start_a[0]), .vfill(vfill_a[0]), .datainp(din_a[0]), .codeoutp(cout_a[0]),
    .rdy(rdy_a[0]), .rfs(rfs_a[0]), .rfd(rfd_a[0]));
  tm_rs_interleave_enc #(.TT(16), .IDEPTH(5)) u1 (.clk(clk), .rst(rst), .clken(clken),
    .start(start_a[1]), .vfill(vfill_a[1]), .datainp(din_a[1]), .codeoutp(cout_a[1]),
    .rdy(rdy_a[1]), .rfs(rfs_a[1]), .rfd(rfd_a[1]));
  tm_rs_interleave_enc #(.TT(8), .IDEPTH(2)) u2 (.clk(clk), .rst(rst), .clken(clken),
    .start(start_a[2]), .vfill(vfill_a[2]), .datainp(din_a[2]), .codeoutp(cout_a[2]),
    .rdy(rdy_a[2]), .rfs(rfs_a[2]), .rfd(rfd_a[2]));

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h87) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] apow(int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e % 255; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // Symbol representation on the pins (dual basis when that build is selected).
  function automatic logic [7:0] cv(logic [7:0] x);
`ifdef TM_RSENC_DUALBASIS_EN
    logic [7:0] y, t, acc;
    for (int k = 0; k < 8; k++) begin
      t = gmul(x, apow(117 * k));
      acc = t;
      for (int i = 1; i < 8; i++) begin
        t = gmul(t, t);
        acc ^= t;
      end
      y[k] = acc[0];
    end
    return y;
`else
    return x;
`endif
  endfunction

  // g(x) = prod (x + alpha^(11*(128-tt+j))); gtab[s][d] is the x^d coefficient.
  task automatic build_gen(int s, int tt);
    logic [7:0] g [0:32];
    logic [7:0] r;
    for (int d = 0; d <= 32; d++) g[d] = 8'h00;
    g[0] = 8'h01;
    for (int j = 0; j < 2 * tt; j++) begin
      r = apow(11 * (128 - tt + j));
      for (int d = j + 1; d > 0; d--) g[d] = g[d-1] ^ gmul(g[d], r);
      g[0] = gmul(g[0], r);
    end
    for (int d = 0; d <= 32; d++) gtab[s][d] = g[d];
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (clken)
      for (int u = 0; u < 3; u++)
        if (rdy_a[u]) begin
          if (sbq.size() == 0) chk("extra_out", 32'(u), 32'hEE);
          else begin
            e = sbq.pop_front();
            chk("out", (32'(u) << 8) | 32'(cout_a[u]), (32'(e.unit) << 8) | 32'(e.val));
          end
        end
  end

  // mode: 0 zeros, 1 zeros then 0x01 (parity must equal generator), 2 random.
  task automatic run_block(int u, int vf, int mode, bit noisy, bit rclk, int abort_at);
    int tt, id, np, kmax, k, d, gs, idx, guard, n_feed;
    logic [7:0] data [];
    logic [7:0] c [];
    logic [7:0] par [8][32];
    logic [7:0] qv;
    bit rfs_b, rfd_b;
    tt = TT_OF[u]; id = ID_OF[u]; np = 2 * tt; kmax = 255 - np;
    gs = (tt == 16) ? 1 : 0;
    k = kmax - ((vf > kmax - 1) ? kmax - 1 : vf);
    d = id * k;
    data = new[d];
    for (int n = 0; n < d; n++) data[n] = (mode == 2) ? 8'($urandom) : 8'h00;
    if (mode == 1) data[d-1] = 8'h01;
    for (int l = 0; l < id; l++) begin
      c = new[k + np];
      for (int i = 0; i < k + np; i++) c[i] = (i < k) ? data[l + i * id] : 8'h00;
      for (int i = 0; i < k; i++) begin
        qv = c[i];
        for (int kk = 0; kk <= np; kk++) c[i+kk] ^= gmul(qv, gtab[gs][np-kk]);
      end
      for (int j = 0; j < np; j++) par[l][j] = (mode == 1) ? gtab[gs][j] : c[k+np-1-j];
    end
    n_feed = (abort_at >= 0) ? abort_at : d;
    for (int n = 0; n < n_feed; n++) sbq.push_back('{u, int'(cv(data[n]))});
    if (abort_at < 0)
      for (int j = np - 1; j >= 0; j--)
        for (int l = 0; l < id; l++) sbq.push_back('{u, int'(cv(par[l][j]))});

    idx = 0; guard = 0;
    vfill_a[u] = 8'(vf);
    while (idx < n_feed && guard < LIM) begin
      clken = rclk ? ($urandom_range(0, 3) != 0) : 1'b1;
      start_a[u] = (idx == 0) || noisy;
      if (idx > 0 && noisy) vfill_a[u] = 8'($urandom);
      din_a[u] = cv(data[idx]);
      rfs_b = rfs_a[u];
      rfd_b = rfd_a[u];
      @(posedge clk); #1;
      if (clken && ((idx == 0) ? rfs_b : rfd_b)) idx++;
      guard++;
    end
    start_a[u] = 1'b0;
    din_a[u] = 8'($urandom);
    clken = 1'b1;
    chk("feed_timeout", 32'(guard < LIM), 1);

    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_rdy", 32'(rdy_a[u]), 0);
      chk("abort_rfs", 32'(rfs_a[u]), 1);
      chk("abort_rfd", 32'(rfd_a[u]), 0);
      chk("abort_sbq", 32'(sbq.size()), 0);
    end
  endtask

  task automatic drain(int u);
    int n;
    n = 0;
    clken = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (sbq.size() != 0 && n < LIM);
    chk("drain_left", 32'(sbq.size()), 0);
    chk("end_rfs", 32'(rfs_a[u]), 1);
    chk("end_rdy", 32'(rdy_a[u]), 0);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      vfill_a[u] = 8'h00;
      din_a[u] = 8'h00;
    end
    build_gen(0, 8);
    build_gen(1, 16);
    rst = 1'b1;
    clken = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      chk("rst_codeoutp", 32'(cout_a[u]), 0);
      chk("rst_rdy", 32'(rdy_a[u]), 0);
      chk("rst_rfs", 32'(rfs_a[u]), 1);
      chk("rst_rfd", 32'(rfd_a[u]), 0);
    end

    run_block(0, 0, 0, 1'b0, 1'b0, -1);   drain(0);  // all-zero block
    run_block(0, 0, 1, 1'b0, 1'b0, -1);   drain(0);  // parity == generator
    run_block(1, 0, 2, 1'b0, 1'b0, -1);   drain(1);  // I=5 random, 1275 symbols
    run_block(2, 200, 2, 1'b0, 1'b0, -1); drain(2);  // K=39
    run_block(2, 255, 2, 1'b0, 1'b0, -1); drain(2);  // K clamped to 1
    run_block(1, 30, 2, 1'b1, 1'b1, -1);  drain(1);  // random CLKEN, START noise
    run_block(2, 150, 2, 1'b0, 1'b0, -1);            // back-to-back blocks
    run_block(2, 180, 2, 1'b1, 1'b0, -1);
    run_block(2, 255, 2, 1'b0, 1'b0, -1); drain(2);
    run_block(0, 0, 2, 1'b0, 1'b0, 100);  drain(0);  // reset mid-block
    run_block(0, 10, 2, 1'b0, 1'b0, -1);  drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
